// File: rtl/bounded_updown_counter_pkg.sv
// bounded_updown_counter_pkg: op encodings shared by the bounded up/down counter and its legacy predecessor
package bounded_updown_counter_pkg;
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;
endpackage

// File: rtl/bounded_updown_counter_prescale_tick.sv
// prescale_tick: emits one tick per DIV advancing cycles; pure pass-through when DIV=1
module prescale_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic tick
);
    generate
        if (DIV == 1) begin : g_bypass
            logic unused;
            assign unused = clk ^ rst_n ^ clr;
            assign tick = adv;
        end else begin : g_div
            localparam int PW = $clog2(DIV);
            logic [PW-1:0] cnt;
            assign tick = adv && cnt == PW'(DIV - 1);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt <= '0;
                else if (clr) cnt <= '0;
                else if (adv) cnt <= tick ? '0 : cnt + 1'b1;
            end
        end
    endgenerate
endmodule

// File: rtl/bounded_updown_counter.sv
// bounded_updown_counter: up/down counter with programmable step, runtime bounds,
// wrap/saturate mode, synchronous load, enable prescaler and registered crossing pulses
module bounded_updown_counter
    import bounded_updown_counter_pkg::*;
#(
    parameter int           W       = 4,
    parameter int           DIV     = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   op,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] step,
    input  logic [W-1:0] lim_lo,
    input  logic [W-1:0] lim_hi,
    input  logic         wrap,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         ovf,
    output logic         unf,
    output logic         cfg_err
);
    logic               tick, adv, clr, act;
    logic               ovf_n, unf_n;
    logic [W:0]         sum;
    logic signed [W:0]  diff;
    logic [W-1:0]       nxt;

    assign clr     = load || op == OP_CLR;
    assign adv     = en && !load && (op == OP_INC || op == OP_DEC);
    assign cfg_err = lim_lo > lim_hi;
    assign at_max  = count == lim_hi;
    assign at_min  = count == lim_lo;
    assign sum     = {1'b0, count} + {1'b0, step};
    assign diff    = $signed({1'b0, count}) - $signed({1'b0, step});
    // a tick is consumed even when it cannot move the count
    assign act     = tick && !cfg_err && step != '0;

    prescale_tick #(.DIV(DIV)) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .adv  (adv),
        .tick (tick)
    );

    always_comb begin
        ovf_n = act && op == OP_INC && sum > {1'b0, lim_hi};
        unf_n = act && op == OP_DEC && diff < $signed({1'b0, lim_lo});
        nxt   = load         ? load_val :
                op == OP_CLR ? lim_lo :
                !act         ? count :
                ovf_n        ? (wrap ? lim_lo : lim_hi) :
                unf_n        ? (wrap ? lim_hi : lim_lo) :
                op == OP_INC ? sum[W-1:0] : diff[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= nxt;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end
endmodule

// File: tb/tb_bounded_updown_counter.sv
// tb_bounded_updown_counter: DIV=1 and DIV=3 instances driven in parallel and checked
// against an integer-arithmetic reference model
module tb_bounded_updown_counter;
    logic       clk = 0, rst_n = 0, en = 0, load = 0, wrap = 0;
    logic [1:0] op = 0;
    logic [3:0] load_val = 0, step = 0, lim_lo = 0, lim_hi = 0, tmp;
    logic [3:0] cnt [2];
    logic       amax [2], amin [2], ovf [2], unf [2], cerr [2];
    int         n_tests = 0, n_fail = 0;
    int         divs [2] = '{1, 3};
    int         rsts [2] = '{0, 3};
    int         mc [2], mp [2];
    bit         mo [2], mu [2];
    int         en_pat [4] = '{1, 0, 1, 1};
    int         exp3 [4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    bounded_updown_counter #(.W(4), .DIV(1), .RST_VAL(4'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .load(load), .load_val(load_val),
        .step(step), .lim_lo(lim_lo), .lim_hi(lim_hi), .wrap(wrap), .count(cnt[0]),
        .at_max(amax[0]), .at_min(amin[0]), .ovf(ovf[0]), .unf(unf[0]), .cfg_err(cerr[0]));

    bounded_updown_counter #(.W(4), .DIV(3), .RST_VAL(4'd3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .load(load), .load_val(load_val),
        .step(step), .lim_lo(lim_lo), .lim_hi(lim_hi), .wrap(wrap), .count(cnt[1]),
        .at_max(amax[1]), .at_min(amin[1]), .ovf(ovf[1]), .unf(unf[1]), .cfg_err(cerr[1]));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = rsts[k];
            mp[k] = 0;
            mo[k] = 0;
            mu[k] = 0;
        end
    endtask

    task automatic model_step();
        int lo, hi, s;
        lo = int'(lim_lo);
        hi = int'(lim_hi);
        s  = int'(step);
        for (int k = 0; k < 2; k++) begin
            mo[k] = 0;
            mu[k] = 0;
            if (load) begin
                mc[k] = int'(load_val);
                mp[k] = 0;
            end else if (op == 2'b11) begin
                mc[k] = lo;
                mp[k] = 0;
            end else if (en && (op == 2'b01 || op == 2'b10)) begin
                mp[k]++;
                if (mp[k] == divs[k]) begin
                    mp[k] = 0;
                    if (lo <= hi && s != 0) begin
                        if (op == 2'b01) begin
                            if (mc[k] + s <= hi) mc[k] += s;
                            else begin mc[k] = wrap ? lo : hi; mo[k] = 1; end
                        end else begin
                            if (mc[k] - s >= lo) mc[k] -= s;
                            else begin mc[k] = wrap ? hi : lo; mu[k] = 1; end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_count%0d", tag, k), int'(cnt[k]), mc[k]);
            check($sformatf("%s_ovf%0d", tag, k), int'(ovf[k]), int'(mo[k]));
            check($sformatf("%s_unf%0d", tag, k), int'(unf[k]), int'(mu[k]));
            check($sformatf("%s_atmax%0d", tag, k), int'(amax[k]), int'(mc[k] == int'(lim_hi)));
            check($sformatf("%s_atmin%0d", tag, k), int'(amin[k]), int'(mc[k] == int'(lim_lo)));
            check($sformatf("%s_cfgerr%0d", tag, k), int'(cerr[k]), int'(lim_lo > lim_hi));
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1;
        // load 8 then inc by 3 inside [2,9] with wrap
        lim_lo = 2; lim_hi = 9; step = 3; wrap = 1; en = 1;
        load = 1; load_val = 8; op = 2'b00;
        cycle("t1_load");
        check("t1_load_val", int'(cnt[0]), 8);
        load = 0; op = 2'b01;
        cycle("t1_wrap");
        check("t1_wrap_cnt", int'(cnt[0]), 2);
        check("t1_wrap_ovf", int'(ovf[0]), 1);
        cycle("t1_next");
        check("t1_next_cnt", int'(cnt[0]), 5);
        check("t1_next_ovf", int'(ovf[0]), 0);
        // saturate at 9
        wrap = 0; load = 1; load_val = 9;
        cycle("t2_load");
        load = 0;
        repeat (3) begin
            cycle("t2_sat");
            check("t2_sat_cnt", int'(cnt[0]), 9);
            check("t2_sat_ovf", int'(ovf[0]), 1);
            check("t2_sat_atmax", int'(amax[0]), 1);
        end
        // DIV=3 prescaler with gated enable
        lim_lo = 0; lim_hi = 15; step = 1; op = 2'b11;
        cycle("t3_clr");
        op = 2'b01;
        for (int i = 0; i < 4; i++) begin
            en = 1'(en_pat[i]);
            cycle("t3_div");
            check($sformatf("t3_div3_cnt%0d", i), int'(cnt[1]), exp3[i]);
        end
        // inverted bounds
        lim_lo = 5; lim_hi = 3; en = 1; op = 2'b01; step = 2;
        load = 1; load_val = 1;
        cycle("t4_load");
        load = 0;
        cycle("t4_inc");
        check("t4_cfgerr", int'(cerr[0]), 1);
        check("t4_inc_hold", int'(cnt[0]), 1);
        op = 2'b10;
        cycle("t4_dec");
        load = 1; load_val = 7;
        cycle("t4_load7");
        check("t4_load7_cnt", int'(cnt[0]), 7);
        load = 0; op = 2'b11;
        cycle("t4_clear");
        check("t4_clear_cnt", int'(cnt[0]), 5);
        // load beats clear on the same edge and clears the prescaler
        lim_lo = 0; lim_hi = 15; step = 1; wrap = 1; op = 2'b01;
        cycle("t6_pre");
        load = 1; load_val = 4; op = 2'b11;
        cycle("t6_load_clr");
        check("t6_load_cnt", int'(cnt[1]), 4);
        load = 0; op = 2'b01;
        cycle("t6_a");
        cycle("t6_b");
        check("t6_b_cnt", int'(cnt[1]), 4);
        cycle("t6_c");
        check("t6_c_cnt", int'(cnt[1]), 5);
        // async reset between edges while ovf is high
        load = 1; load_val = 15; op = 2'b00;
        cycle("t5_load");
        load = 0; op = 2'b01;
        cycle("t5_ovf");
        check("t5_ovf_high", int'(ovf[0]), 1);
        #2 rst_n = 0;
        #1;
        check("t5_async_cnt0", int'(cnt[0]), 0);
        check("t5_async_cnt1", int'(cnt[1]), 3);
        check("t5_async_ovf0", int'(ovf[0]), 0);
        check("t5_async_unf1", int'(unf[1]), 0);
        model_reset();
        @(negedge clk);
        check_all("t5_held");
        rst_n = 1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 32 == 0) begin
                lim_lo = 4'($urandom);
                lim_hi = 4'($urandom);
                if (lim_lo > lim_hi && $urandom % 4 != 0) begin
                    tmp = lim_lo; lim_lo = lim_hi; lim_hi = tmp;
                end
            end
            step = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 3);
            wrap = 1'($urandom % 2);
            en = ($urandom % 4) != 0;
            r = int'($urandom % 10);
            op = r == 0 ? 2'b00 : r < 5 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
            load = ($urandom % 20) == 0;
            load_val = 4'($urandom);
            cycle("rand");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
